// File: rtl/game_ctrl_fsm_p_if.sv
// game_ctrl_if: bundles the game-state controller's input events and its
// registered outputs so one connection carries the whole controller bus.
//
// Signals
//   hitwall, hitbody  : collision events from the snake logic
//   key[KEY_N]        : debounced direction/start key levels
//   pause_key         : pause toggle key level
//   score[SCORE_W]    : current score
//   status[3]         : game state (0 RESTART .. 6 WIN)
//   restart           : snake/food reset request
//   die_blink         : snake-visible flag for the renderer
//   score_flag        : scoreboard latch request
//   lives_left[4]     : remaining lives
//   game_over, win    : end-of-game indicators
//
// Modports
//   master : game side, drives events and observes status
//   slave  : the controller itself
interface game_ctrl_if #(
  parameter int KEY_N   = 4,
  parameter int SCORE_W = 16
);
  logic               hitwall;
  logic               hitbody;
  logic [KEY_N-1:0]   key;
  logic               pause_key;
  logic [SCORE_W-1:0] score;

  logic [2:0]         status;
  logic               restart;
  logic               die_blink;
  logic               score_flag;
  logic [3:0]         lives_left;
  logic               game_over;
  logic               win;

  modport master (
    output hitwall, hitbody, key, pause_key, score,
    input  status, restart, die_blink, score_flag, lives_left, game_over, win
  );

  modport slave (
    input  hitwall, hitbody, key, pause_key, score,
    output status, restart, die_blink, score_flag, lives_left, game_over, win
  );
endinterface

// File: rtl/game_ctrl_fsm_p.sv
// game_ctrl_fsm_p: snake game-state controller.
//   RESTART -> START -> PLAY -> DIE / WIN / OVER, with multiple lives,
//   a configurable win score, edge-detected keys and an optional pause.
//
// Ports
//   clk : 25 MHz game clock
//   rst : synchronous active-high reset
//   gif : game_ctrl_if.slave bundle (events in, registered status out)
//
// Build option
//   GAME_PAUSE_EN : when defined, a pause_key rising edge in PLAY enters
//                   PAUSE (status 4) and a second one resumes. When not
//                   defined, pause_key is ignored and status never reads 4.
//
// All outputs come straight from flops.
module game_ctrl_fsm_p #(
  parameter int KEY_N       = 4,
  parameter int SCORE_W     = 16,
  parameter int WIN_SCORE   = 256,
  parameter int LIVES       = 3,
  parameter int RESTART_CYC = 21,
  parameter int BLINK_PER   = 25_000_000,
  parameter int BLINK_N     = 6,
  parameter int DIE_CYC     = 200_000_000
) (
  input  logic        clk,
  input  logic        rst,
  game_ctrl_if.slave  gif
);

  localparam int CNT_MAX = (RESTART_CYC > DIE_CYC) ? RESTART_CYC : DIE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] RESTART_LAST = CNT_W'(RESTART_CYC - 1);
  localparam logic [CNT_W-1:0] DIE_LAST     = CNT_W'(DIE_CYC - 1);
  localparam logic [3:0]       LIVES_INIT   = 4'(LIVES);

  typedef enum logic [2:0] {
    S_RESTART = 3'd0,
    S_START   = 3'd1,
    S_PLAY    = 3'd2,
    S_DIE     = 3'd3,
    S_PAUSE   = 3'd4,
    S_OVER    = 3'd5,
    S_WIN     = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             restart_q, restart_d;
  logic             die_blink_q, die_blink_d;
  logic             score_flag_q, score_flag_d;
  logic [3:0]       lives_q, lives_d;
  logic             game_over_q, game_over_d;
  logic             win_q, win_d;
  logic             key_q, key_d;

  // OR-reduce the key inputs; any key counts as "a key".
  logic [KEY_N:0] key_chain;
  assign key_chain[0] = 1'b0;
  for (genvar gi = 0; gi < KEY_N; gi++) begin : g_key_or
    assign key_chain[gi+1] = key_chain[gi] | gif.key[gi];
  end

  logic key_any;
  logic key_evt;
  assign key_any = key_chain[KEY_N];
  assign key_evt = key_any & ~key_q;

  // die_blink flips as cnt steps onto k*BLINK_PER, so match one cycle early
  // (cnt_q == k*BLINK_PER-1) and let the flop update together with cnt.
  logic [BLINK_N-1:0] blink_match;
  for (genvar gi = 0; gi < BLINK_N; gi++) begin : g_blink
    assign blink_match[gi] = (cnt_q == CNT_W'((gi + 1) * BLINK_PER - 1));
  end

  logic blink_step;
  assign blink_step = |blink_match;

  logic hit;
  logic score_won;
  assign hit       = gif.hitwall | gif.hitbody;
  assign score_won = (gif.score >= SCORE_W'(WIN_SCORE));

`ifdef GAME_PAUSE_EN
  logic pause_q, pause_d;
  logic pause_evt;
  assign pause_d   = gif.pause_key;
  assign pause_evt = gif.pause_key & ~pause_q;
`else
  logic unused_pause_key;
  assign unused_pause_key = gif.pause_key;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    restart_d   = 1'b0;
    die_blink_d = die_blink_q;
    lives_d     = lives_q;
    key_d       = key_any;

    case (state_q)
      S_RESTART: begin
        // restart_q is low here only on the first cycle after reset; use
        // that cycle to arm the pulse so it always lasts RESTART_CYC cycles.
        if (!restart_q) begin
          restart_d = 1'b1;
          cnt_d     = '0;
        end else if (cnt_q == RESTART_LAST) begin
          state_d = S_START;
          cnt_d   = '0;
        end else begin
          restart_d = 1'b1;
          cnt_d     = cnt_q + CNT_W'(1);
        end
      end

      S_START: begin
        if (key_evt) begin
          state_d = S_PLAY;
        end
      end

      S_PLAY: begin
        if (hit) begin
          state_d = S_DIE;
          cnt_d   = '0;
          lives_d = (lives_q != 4'd0) ? lives_q - 4'd1 : 4'd0;
        end else if (score_won) begin
          state_d = S_WIN;
        end
`ifdef GAME_PAUSE_EN
        else if (pause_evt) begin
          state_d = S_PAUSE;
        end
`endif
      end

      S_DIE: begin
        if (cnt_q == DIE_LAST) begin
          cnt_d       = '0;
          die_blink_d = 1'b1;
          if (lives_q != 4'd0) begin
            state_d   = S_RESTART;
            restart_d = 1'b1;
          end else begin
            state_d = S_OVER;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (blink_step) begin
            die_blink_d = ~die_blink_q;
          end
        end
      end

`ifdef GAME_PAUSE_EN
      S_PAUSE: begin
        // cnt is left untouched; hits and score are not looked at.
        if (pause_evt) begin
          state_d = S_PLAY;
        end
      end
`endif

      S_OVER, S_WIN: begin
        if (key_evt) begin
          state_d   = S_RESTART;
          restart_d = 1'b1;
          cnt_d     = '0;
          lives_d   = LIVES_INIT;
        end
      end

      default: begin
        state_d     = S_RESTART;
        restart_d   = 1'b1;
        cnt_d       = '0;
        die_blink_d = 1'b1;
      end
    endcase

    // game_over/win track the state being entered so they line up with
    // status; score_flag looks at the current state and so lags by a cycle.
    game_over_d  = (state_d == S_OVER);
    win_d        = (state_d == S_WIN);
    score_flag_d = (state_q == S_DIE) || (state_q == S_OVER) || (state_q == S_WIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_RESTART;
      cnt_q        <= '0;
      restart_q    <= 1'b0;
      die_blink_q  <= 1'b1;
      score_flag_q <= 1'b0;
      lives_q      <= LIVES_INIT;
      game_over_q  <= 1'b0;
      win_q        <= 1'b0;
      key_q        <= 1'b0;
`ifdef GAME_PAUSE_EN
      pause_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      restart_q    <= restart_d;
      die_blink_q  <= die_blink_d;
      score_flag_q <= score_flag_d;
      lives_q      <= lives_d;
      game_over_q  <= game_over_d;
      win_q        <= win_d;
      key_q        <= key_d;
`ifdef GAME_PAUSE_EN
      pause_q      <= pause_d;
`endif
    end
  end

  assign gif.status     = state_q;
  assign gif.restart    = restart_q;
  assign gif.die_blink  = die_blink_q;
  assign gif.score_flag = score_flag_q;
  assign gif.lives_left = lives_q;
  assign gif.game_over  = game_over_q;
  assign gif.win        = win_q;

endmodule

// File: tb/tb_game_ctrl_fsm_p.sv
// Bench for game_ctrl_fsm_p: a constant vector table for the scripted game
// flow, a reference model checked every cycle, a randomized phase and a
// hand-written restart-length sequence.
module tb_game_ctrl_fsm_p;

  localparam int RESTART_CYC = 3;
  localparam int BLINK_PER   = 4;
  localparam int BLINK_N     = 2;
  localparam int DIE_CYC     = 12;
  localparam int LIVES       = 2;
  localparam int WIN_SCORE   = 5;
`ifdef GAME_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  game_ctrl_if #(.KEY_N(4), .SCORE_W(16)) gif ();

  game_ctrl_fsm_p #(
    .KEY_N(4), .SCORE_W(16), .WIN_SCORE(WIN_SCORE), .LIVES(LIVES),
    .RESTART_CYC(RESTART_CYC), .BLINK_PER(BLINK_PER), .BLINK_N(BLINK_N),
    .DIE_CYC(DIE_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .gif(gif)
  );

  typedef struct packed {
    logic [2:0] status;
    logic       restart;
    logic       blink;
    logic       sflag;
    logic [3:0] lives;
    logic       go;
    logic       win;
  } out_t;

  typedef struct {
    bit          rst;
    bit          hw;
    bit          hb;
    logic [3:0]  key;
    bit          pk;
    logic [15:0] score;
    int          n;
    out_t        exp;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: status plus time spent in it.
  int m_status, m_t, m_lives;
  bit m_from_rst, m_prev_key, m_prev_pause, m_sflag;

  function automatic out_t cur_out();
    out_t o;
    o.status  = gif.status;
    o.restart = gif.restart;
    o.blink   = gif.die_blink;
    o.sflag   = gif.score_flag;
    o.lives   = gif.lives_left;
    o.go      = gif.game_over;
    o.win     = gif.win;
    return o;
  endfunction

  function automatic out_t model_out();
    out_t o;
    int   k;
    o.status  = 3'(m_status);
    o.restart = (m_status == 0) && (!m_from_rst || m_t >= 1);
    k = m_t / BLINK_PER;
    if (k > BLINK_N) k = BLINK_N;
    o.blink   = (m_status == 3) ? ((k % 2) == 0) : 1'b1;
    o.sflag   = m_sflag;
    o.lives   = 4'(m_lives);
    o.go      = (m_status == 5);
    o.win     = (m_status == 6);
    return o;
  endfunction

  task automatic model_step();
    bit kany, kevt, pevt;
    int nxt, len;
    if (rst) begin
      m_status = 0; m_t = 0; m_lives = LIVES; m_from_rst = 1'b1;
      m_prev_key = 1'b0; m_prev_pause = 1'b0; m_sflag = 1'b0;
    end else begin
      kany = |gif.key;
      kevt = kany && !m_prev_key;
      pevt = gif.pause_key && !m_prev_pause;
      nxt  = m_status;
      case (m_status)
        0: begin
          len = m_from_rst ? RESTART_CYC + 1 : RESTART_CYC;
          if (m_t + 1 >= len) nxt = 1;
        end
        1: if (kevt) nxt = 1 + 1;
        2: begin
          if (gif.hitwall || gif.hitbody) begin
            nxt = 3;
            if (m_lives > 0) m_lives = m_lives - 1;
          end else if (int'(gif.score) >= WIN_SCORE) nxt = 6;
          else if (PAUSE_EN && pevt) nxt = 4;
        end
        3: if (m_t == DIE_CYC - 1) nxt = (m_lives != 0) ? 0 : 5;
        4: if (pevt) nxt = 2;
        5, 6: if (kevt) begin nxt = 0; m_lives = LIVES; end
        default: nxt = 0;
      endcase
      m_sflag = (m_status == 3) || (m_status == 5) || (m_status == 6);
      if (nxt != m_status) begin
        m_t = 0;
        if (nxt == 0) m_from_rst = 1'b0;
      end else begin
        m_t++;
      end
      m_status     = nxt;
      m_prev_key   = kany;
      m_prev_pause = gif.pause_key;
    end
  endtask

  task automatic check_out(string name, out_t exp);
    out_t act;
    act = cur_out();
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got st=%0d rs=%0b bl=%0b sf=%0b lv=%0d go=%0b win=%0b, want st=%0d rs=%0b bl=%0b sf=%0b lv=%0d go=%0b win=%0b",
                  name, act.status, act.restart, act.blink, act.sflag, act.lives, act.go, act.win,
                  exp.status, exp.restart, exp.blink, exp.sflag, exp.lives, exp.go, exp.win);
  endtask

  task automatic check_int(string name, int got, int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, got, want);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_out("model", model_out());
  endtask

  function automatic vec_t v(bit r, bit hw, bit hb, logic [3:0] k, bit pk, int sc, int n,
                             int st, bit rs, bit bl, bit sf, int lv, bit go, bit wn);
    vec_t x;
    x.rst = r; x.hw = hw; x.hb = hb; x.key = k; x.pk = pk; x.score = 16'(sc); x.n = n;
    x.exp.status = 3'(st); x.exp.restart = rs; x.exp.blink = bl; x.exp.sflag = sf;
    x.exp.lives = 4'(lv); x.exp.go = go; x.exp.win = wn;
    return x;
  endfunction

  vec_t vecs[$];

  initial begin
    int hi;
    int pst;
    //                 rst hw hb key     pk sc n   st rs bl sf lv go wn
    vecs.push_back(v(1, 0, 0, 4'b0000, 0, 0, 2,  0, 0, 1, 0, 2, 0, 0)); // reset
    vecs.push_back(v(0, 0, 0, 4'b0000, 0, 0, 1,  0, 1, 1, 0, 2, 0, 0));
    vecs.push_back(v(0, 0, 0, 4'b0000, 0, 0, 2,  0, 1, 1, 0, 2, 0, 0));
    vecs.push_back(v(0, 0, 0, 4'b0000, 0, 0, 1,  1, 0, 1, 0, 2, 0, 0)); // START
    vecs.push_back(v(0, 0, 0, 4'b0100, 0, 0, 1,  2, 0, 1, 0, 2, 0, 0)); // key -> PLAY
    vecs.push_back(v(0, 0, 0, 4'b0100, 0, 0, 3,  2, 0, 1, 0, 2, 0, 0));
    vecs.push_back(v(0, 1, 0, 4'b0100, 0, 0, 1,  3, 0, 1, 0, 1, 0, 0)); // hitwall
    vecs.push_back(v(0, 0, 0, 4'b0100, 0, 0, 1,  3, 0, 1, 1, 1, 0, 0)); // cnt1
    vecs.push_back(v(0, 0, 0, 4'b0100, 0, 0, 2,  3, 0, 1, 1, 1, 0, 0)); // cnt3
    vecs.push_back(v(0, 0, 0, 4'b0100, 0, 0, 1,  3, 0, 0, 1, 1, 0, 0)); // cnt4 blink off
    vecs.push_back(v(0, 0, 0, 4'b0100, 0, 0, 3,  3, 0, 0, 1, 1, 0, 0)); // cnt7
    vecs.push_back(v(0, 0, 0, 4'b0100, 0, 0, 1,  3, 0, 1, 1, 1, 0, 0)); // cnt8 blink on
    vecs.push_back(v(0, 0, 0, 4'b0100, 0, 0, 3,  3, 0, 1, 1, 1, 0, 0)); // cnt11
    vecs.push_back(v(0, 0, 0, 4'b0100, 0, 0, 1,  0, 1, 1, 1, 1, 0, 0)); // respawn
    vecs.push_back(v(0, 0, 0, 4'b0100, 0, 0, 2,  0, 1, 1, 0, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 4'b0100, 0, 0, 1,  1, 0, 1, 0, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 4'b0100, 0, 0, 2,  1, 0, 1, 0, 1, 0, 0)); // held: no retrigger
    vecs.push_back(v(0, 0, 0, 4'b0000, 0, 0, 1,  1, 0, 1, 0, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 4'b0001, 0, 0, 1,  2, 0, 1, 0, 1, 0, 0));
    vecs.push_back(v(0, 0, 1, 4'b0000, 0, 0, 1,  3, 0, 1, 0, 0, 0, 0)); // last life
    vecs.push_back(v(0, 0, 0, 4'b0000, 0, 0, 11, 3, 0, 1, 1, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 4'b0000, 0, 0, 1,  5, 0, 1, 1, 0, 1, 0)); // OVER
    vecs.push_back(v(0, 0, 0, 4'b0000, 0, 0, 2,  5, 0, 1, 1, 0, 1, 0));
    vecs.push_back(v(0, 0, 0, 4'b1000, 0, 0, 1,  0, 1, 1, 1, 2, 0, 0)); // lives reload
    vecs.push_back(v(0, 0, 0, 4'b0000, 0, 0, 3,  1, 0, 1, 0, 2, 0, 0));
    vecs.push_back(v(0, 0, 0, 4'b0010, 0, 0, 1,  2, 0, 1, 0, 2, 0, 0));
    vecs.push_back(v(0, 0, 0, 4'b0000, 0, 5, 1,  6, 0, 1, 0, 2, 0, 1)); // WIN
    vecs.push_back(v(0, 0, 0, 4'b0000, 0, 5, 1,  6, 0, 1, 1, 2, 0, 1));
    vecs.push_back(v(0, 0, 0, 4'b0001, 0, 0, 1,  0, 1, 1, 1, 2, 0, 0));
    vecs.push_back(v(0, 0, 0, 4'b0000, 0, 0, 3,  1, 0, 1, 0, 2, 0, 0));
    vecs.push_back(v(0, 0, 0, 4'b0100, 0, 0, 1,  2, 0, 1, 0, 2, 0, 0));
    vecs.push_back(v(0, 0, 1, 4'b0000, 0, 5, 1,  3, 0, 1, 0, 1, 0, 0)); // hit beats win
    vecs.push_back(v(0, 0, 0, 4'b0000, 0, 0, 7,  3, 0, 0, 1, 1, 0, 0)); // cnt7
    vecs.push_back(v(1, 0, 0, 4'b0000, 0, 0, 1,  0, 0, 1, 0, 2, 0, 0)); // rst in DIE
    vecs.push_back(v(0, 0, 0, 4'b0000, 0, 0, 4,  1, 0, 1, 0, 2, 0, 0));
    vecs.push_back(v(0, 0, 0, 4'b0001, 0, 0, 1,  2, 0, 1, 0, 2, 0, 0));
    vecs.push_back(v(0, 0, 0, 4'b0000, 1, 0, 1,  PAUSE_EN ? 4 : 2, 0, 1, 0, 2, 0, 0));
    vecs.push_back(v(0, PAUSE_EN, 0, 4'b0000, 0, 0, 1, PAUSE_EN ? 4 : 2, 0, 1, 0, 2, 0, 0));
    vecs.push_back(v(0, 0, 0, 4'b0000, 1, 0, 1,  2, 0, 1, 0, 2, 0, 0));
    vecs.push_back(v(0, 0, 0, 4'b0000, 0, 0, 2,  2, 0, 1, 0, 2, 0, 0));
    vecs.push_back(v(0, 1, 0, 4'b0000, 1, 0, 1,  3, 0, 1, 0, 1, 0, 0)); // hit beats pause
    vecs.push_back(v(0, 0, 0, 4'b0000, 0, 0, 12, 0, 1, 1, 1, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 4'b0000, 0, 0, 3,  1, 0, 1, 0, 1, 0, 0));

    rst = 1'b1; gif.hitwall = 1'b0; gif.hitbody = 1'b0; gif.key = '0;
    gif.pause_key = 1'b0; gif.score = '0;
    m_status = 0; m_t = 0; m_lives = LIVES; m_from_rst = 1'b1;
    m_prev_key = 1'b0; m_prev_pause = 1'b0; m_sflag = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; gif.hitwall = vecs[i].hw; gif.hitbody = vecs[i].hb;
      gif.key = vecs[i].key; gif.pause_key = vecs[i].pk; gif.score = vecs[i].score;
      for (int c = 0; c < vecs[i].n; c++) tick();
      $display("vec %0d: n=%0d st=%0d rs=%0b bl=%0b sf=%0b lv=%0d go=%0b win=%0b",
               i, vecs[i].n, gif.status, gif.restart, gif.die_blink, gif.score_flag,
               gif.lives_left, gif.game_over, gif.win);
      check_out($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Randomized play against the model.
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(0, 299) == 0);
      gif.hitwall   = ($urandom_range(0, 15) == 0);
      gif.hitbody   = ($urandom_range(0, 15) == 0);
      gif.key       = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      gif.pause_key = ($urandom_range(0, 4) == 0);
      gif.score     = ($urandom_range(0, 19) == 0) ? 16'($urandom_range(5, 9))
                                                   : 16'($urandom_range(0, 4));
      tick();
    end
    $display("random phase: 3000 cycles");

    // Restart pulse length straight out of reset, with a bounded wait.
    gif.hitwall = 1'b0; gif.hitbody = 1'b0; gif.key = '0;
    gif.pause_key = 1'b0; gif.score = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (gif.restart) hi++;
      if (gif.status != 3'd0) break;
    end
    pst = int'(gif.status);
    $display("restart sequence: high for %0d cycles, status %0d", hi, pst);
    check_int("restart_len", hi, RESTART_CYC);
    check_int("restart_exit", pst, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
